// File: rtl/vending_fsm.sv
// vending_fsm: two-coin vending controller with serial half-unit change/refund; optional idle auto-refund under `VEND_TIMEOUT_EN
module vending_fsm #(
    parameter int PRICE   = 5,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             pi_money_half,
    input  logic             pi_money_one,
    input  logic             pi_cancel,
    output logic             po_cola,
    output logic             po_change,
    output logic             po_reject,
    output logic             po_busy,
    output logic [CNT_W-1:0] po_credit
);
    localparam logic [3:0] IDLE    = 4'b0001;
    localparam logic [3:0] COLLECT = 4'b0010;
    localparam logic [3:0] VEND    = 4'b0100;
    localparam logic [3:0] CHANGE  = 4'b1000;
    localparam logic [CNT_W:0] PRICE_V = (CNT_W+1)'(PRICE);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic             reject_q, reject_d;
    logic [1:0]       add;
    logic [CNT_W:0]   sum;
    logic             tmo_fire;
    logic             cancel;

    assign add    = {1'b0, pi_money_half} + {pi_money_one, 1'b0};
    assign sum    = {1'b0, credit_q} + {{(CNT_W-1){1'b0}}, add};
    assign cancel = pi_cancel | tmo_fire;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    assign tmo_fire = (state_q == COLLECT) && (add == 2'd0) && (tmo_q == TW'(TIMEOUT - 1));

    // idle-cycle counter: runs only while collecting with no coin arriving
    always_comb tmo_d = ((state_q == COLLECT) && (add == 2'd0) && !tmo_fire) ? tmo_q + 1'b1 : '0;

    // timeout counter register
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) tmo_q <= '0;
        else         tmo_q <= tmo_d;
`else
    // auto-refund is compiled out; credit is held in COLLECT indefinitely
    assign tmo_fire = (TIMEOUT < 0);
`endif

    // next-state and credit update
    always_comb begin
        state_d  = IDLE;
        credit_d = '0;
        reject_d = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if (cancel && sum != '0) begin
                    state_d  = CHANGE;
                    credit_d = CNT_W'(sum);
                end else if (sum >= PRICE_V) begin
                    state_d  = VEND;
                    credit_d = CNT_W'(sum - PRICE_V);
                end else begin
                    state_d  = (sum != '0) ? COLLECT : IDLE;
                    credit_d = CNT_W'(sum);
                end
            end
            VEND: begin
                state_d  = (credit_q != '0) ? CHANGE : IDLE;
                credit_d = credit_q;
                reject_d = pi_money_half | pi_money_one;
            end
            CHANGE: begin
                state_d  = (credit_q > CNT_W'(1)) ? CHANGE : IDLE;
                credit_d = (credit_q != '0) ? credit_q - 1'b1 : '0;
                reject_d = pi_money_half | pi_money_one;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // state, credit and reject registers
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end

    assign po_cola   = (state_q == VEND);
    assign po_change = (state_q == CHANGE);
    assign po_busy   = po_cola | po_change;
    assign po_reject = reject_q;
    assign po_credit = credit_q;
endmodule

// File: tb/tb_vending_fsm.sv
// tb_vending_fsm: directed self-checking bench for vending_fsm (PRICE=5, CNT_W=4, TIMEOUT=8)
module tb_vending_fsm;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       pi_money_half = 1'b0;
    logic       pi_money_one = 1'b0;
    logic       pi_cancel = 1'b0;
    logic       po_cola, po_change, po_reject, po_busy;
    logic [3:0] po_credit;
    logic [7:0] obs;
    int         errors = 0;
    int         checks = 0;

    vending_fsm #(.PRICE(5), .CNT_W(4), .TIMEOUT(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .pi_money_half(pi_money_half), .pi_money_one(pi_money_one), .pi_cancel(pi_cancel),
        .po_cola(po_cola), .po_change(po_change), .po_reject(po_reject),
        .po_busy(po_busy), .po_credit(po_credit)
    );

    always #5 sys_clk = ~sys_clk;

    // {cola, change, reject, busy, credit[3:0]}
    assign obs = {po_cola, po_change, po_reject, po_busy, po_credit};

    task automatic step(input logic [2:0] s);
        {pi_money_half, pi_money_one, pi_cancel} = s;
        @(posedge sys_clk);
        #1;
        {pi_money_half, pi_money_one, pi_cancel} = 3'b000;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_hold got %h want 00", obs); end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        step(3'b000);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_idle got %h want 00", obs); end
    endtask

    task automatic test_one_coins();
        logic [2:0] s [5] = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        logic [7:0] e [5] = '{8'h02, 8'h04, 8'h91, 8'h51, 8'h00};
        for (int i = 0; i < 5; i++) begin
            step(s[i]);
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL one_coins[%0d] got %h want %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_half_coins();
        logic [2:0] s [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
        logic [7:0] e [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h90, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) begin
            step(s[i]);
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL half_coins[%0d] got %h want %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_dual_coin();
        logic [2:0] s [5] = '{3'b100, 3'b010, 3'b110, 3'b000, 3'b000};
        logic [7:0] e [5] = '{8'h01, 8'h03, 8'h91, 8'h51, 8'h00};
        for (int i = 0; i < 5; i++) begin
            step(s[i]);
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL dual_coin[%0d] got %h want %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_cancel();
        logic [2:0] s [10] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        logic [7:0] e [10] = '{8'h00, 8'h02, 8'h04, 8'h56, 8'h55, 8'h54, 8'h53, 8'h52, 8'h51, 8'h00};
        for (int i = 0; i < 10; i++) begin
            step(s[i]);
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL cancel[%0d] got %h want %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_reject_vend();
        logic [2:0] s [5] = '{3'b010, 3'b010, 3'b010, 3'b101, 3'b000};
        logic [7:0] e [5] = '{8'h02, 8'h04, 8'h91, 8'h71, 8'h00};
        for (int i = 0; i < 5; i++) begin
            step(s[i]);
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL reject_vend[%0d] got %h want %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_reject_reset();
        logic [2:0] s [5] = '{3'b010, 3'b010, 3'b001, 3'b100, 3'b000};
        logic [7:0] e [5] = '{8'h02, 8'h04, 8'h54, 8'h73, 8'h52};
        for (int i = 0; i < 5; i++) begin
            step(s[i]);
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL reject_change[%0d] got %h want %h", i, obs, e[i]); end
        end
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL async_reset got %h want 00", obs); end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(3'b000);
            checks++;
            if (obs !== 8'h00) begin errors++; $display("FAIL post_reset[%0d] got %h want 00", i, obs); end
        end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] want;
        step(3'b010);
        checks++;
        if (obs !== 8'h02) begin errors++; $display("FAIL timeout_coin got %h want 02", obs); end
        for (int i = 1; i <= 10; i++) begin
            step(3'b000);
            want = (i <= 7) ? 8'h02 : (i == 8) ? 8'h52 : (i == 9) ? 8'h51 : 8'h00;
            checks++;
            if (obs !== want) begin errors++; $display("FAIL timeout[%0d] got %h want %h", i, obs, want); end
        end
    endtask
`else
    task automatic test_timeout();
        step(3'b010);
        for (int i = 0; i < 100; i++) begin
            step(3'b000);
            checks++;
            if (obs !== 8'h02) begin errors++; $display("FAIL hold[%0d] got %h want 02", i, obs); end
        end
        step(3'b001);
        checks++;
        if (obs !== 8'h52) begin errors++; $display("FAIL hold_cancel got %h want 52", obs); end
        step(3'b000);
        step(3'b000);
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL hold_idle got %h want 00", obs); end
    endtask
`endif

    initial begin
        test_reset();
        test_one_coins();
        test_half_coins();
        test_dual_coin();
        test_cancel();
        test_reject_vend();
        test_reject_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
